// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Double-buffered digit register commits only at a frame boundary.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    lz_en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic                    ready,
    output logic [3:0]              bcd_code,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_tick
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    r_run;
    logic                    r_lz;
    logic                    r_tick;
    logic                    r_pending;
    logic [DW-1:0]           r_div;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [4*NUM_DIGITS-1:0] r_shadow;

    logic                    w_last_div;
    logic                    w_last_idx;
    logic                    w_bnd;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic [NUM_DIGITS:0]     w_hz;

    assign w_last_div = (r_div == DW'(REFRESH_DIV - 1));
    assign w_last_idx = (r_idx == IW'(NUM_DIGITS - 1));
    assign w_bnd      = r_run & w_last_div & w_last_idx;

    // w_hz[i]: active nibbles i..NUM_DIGITS-1 are all zero
    assign w_hz[NUM_DIGITS] = 1'b1;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hz
        assign w_hz[g] = w_hz[g+1] & (r_active[4*g +: 4] == 4'h0);
    end

    assign w_nib   = r_active[4*r_idx +: 4];
    assign w_blank = r_lz & (r_idx != '0) & w_hz[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            r_lz      <= 1'b0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
            r_div     <= '0;
            r_idx     <= '0;
            r_active  <= '0;
            r_shadow  <= '0;
        end else begin
            r_run  <= enable;
            r_lz   <= lz_en;
            r_tick <= w_bnd;
            if (!r_run) begin
                r_div <= '0;
                r_idx <= '0;
            end else if (w_last_div) begin
                r_div <= '0;
                r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
            // Commit and accept are exclusive: accept needs pending=0
            if (r_pending && (!r_run || w_bnd)) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end else if (load && !r_pending) begin
                r_shadow  <= digits_in;
                r_pending <= 1'b1;
            end
        end
    end

    assign ready      = ~r_pending;
    assign frame_tick = r_tick;
    assign digit_en   = r_run ? (NUM_DIGITS'(1) << r_idx) : '0;
    assign bcd_code   = (!r_run || w_blank) ? 4'hF : w_nib;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: arithmetic reference model plus directed checks.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          lz_en = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits_in = '0;
    logic          ready;
    logic [3:0]    bcd_code;
    logic [ND-1:0] digit_en;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lz_en(lz_en),
        .load(load), .digits_in(digits_in), .ready(ready),
        .bcd_code(bcd_code), .digit_en(digit_en), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: m_p counts running cycles; digit and boundary follow by division.
    bit          m_run, m_lz, m_tick, m_pend;
    int          m_p;
    logic [15:0] m_act, m_sh;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 0; m_lz <= 0; m_tick <= 0; m_pend <= 0;
            m_p <= 0; m_act <= '0; m_sh <= '0;
        end else begin
            automatic bit bnd = m_run && (m_p % (ND*RD) == ND*RD-1);
            m_run  <= enable;
            m_lz   <= lz_en;
            m_tick <= bnd;
            m_p    <= m_run ? m_p + 1 : 0;
            if (m_pend && (!m_run || bnd)) begin
                m_act <= m_sh; m_pend <= 0;
            end else if (load && !m_pend) begin
                m_sh <= digits_in; m_pend <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            automatic int idx = (m_p / RD) % ND;
            automatic int upper = int'(m_act) >> (4*idx);
            automatic int e_en = m_run ? (1 << idx) : 0;
            automatic int e_cd = (!m_run || (m_lz && idx > 0 && upper == 0))
                                 ? 15 : (upper & 15);
            chk("model_en", int'(digit_en), e_en);
            chk("model_code", int'(bcd_code), e_cd);
            chk("model_ready", int'(ready), int'(!m_pend));
            chk("model_tick", int'(frame_tick), int'(m_tick));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic lit(input string nm, input int en, input int cd);
        chk({nm, "_en"}, int'(digit_en), en);
        chk({nm, "_code"}, int'(bcd_code), cd);
    endtask

    int exp_first [4] = '{4, 3, 2, 1};

    initial begin
        #12 rst_n = 1'b1;
        tick();
        lit("reset", 0, 15);
        chk("reset_ready", int'(ready), 1);
        load = 1'b1; digits_in = 16'h1234;
        tick();
        load = 1'b0;
        chk("accept_ready", int'(ready), 0);
        tick();
        chk("commit_idle_ready", int'(ready), 1);
        enable = 1'b1;
        tick();
        // k=0: first running cycle
        for (int k = 0; k < 16; k++) begin
            lit("frame1", 1 << (k/4), exp_first[k/4]);
            chk("frame1_tick", int'(frame_tick), 0);
            tick();
        end
        chk("frame_tick_pulse", int'(frame_tick), 1);
        lit("frame2_start", 1, 4);
        tick(4);
        // k=20: digit 1, request update mid-frame
        load = 1'b1; digits_in = 16'h5678;
        tick();
        chk("pending_ready", int'(ready), 0);
        digits_in = 16'h9999;
        tick();
        load = 1'b0;
        tick(9);
        // k=31: last cycle of old frame
        lit("tear_free_last", 8, 1);
        chk("tear_free_ready", int'(ready), 0);
        tick();
        lit("new_frame", 1, 8);
        chk("ready_after_commit", int'(ready), 1);
        tick(4);
        lit("ignored_load", 2, 7);
        // k=36: leading-zero suppression with 0040
        lz_en = 1'b1; load = 1'b1; digits_in = 16'h0040;
        tick();
        load = 1'b0;
        tick(11);
        lit("lz_d0", 1, 0);
        tick(4);
        lit("lz_d1", 2, 4);
        tick(4);
        lit("lz_d2", 4, 15);
        tick(4);
        lit("lz_d3", 8, 15);
        load = 1'b1; digits_in = 16'h0000;
        tick();
        load = 1'b0;
        tick(3);
        lit("lz0_d0", 1, 0);
        tick(4);
        lit("lz0_d1", 2, 15);
        tick(4);
        lit("lz0_d2", 4, 15);
        tick(4);
        lit("lz0_d3", 8, 15);
        lz_en = 1'b0;
        tick(12);
        // k=88: idx=2, drop enable
        lit("pre_drop", 4, 0);
        enable = 1'b0;
        tick();
        lit("dark", 0, 15);
        tick();
        enable = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            lit("restart_dwell", 1, 0);
            tick();
        end
        lit("restart_next", 2, 0);
        // mid-handshake async reset discards pending data
        load = 1'b1; digits_in = 16'h1111;
        tick();
        load = 1'b0;
        chk("pre_reset_ready", int'(ready), 0);
        #3 rst_n = 1'b0;
        #1;
        lit("async_reset", 0, 15);
        chk("async_reset_ready", int'(ready), 1);
        chk("async_reset_tick", int'(frame_tick), 0);
        #10 rst_n = 1'b1;
        tick(2);
        lit("post_reset", 1, 0);
        tick(8);
        lit("post_reset_d2", 4, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
